// File: rtl/n_bit_iter_shifter.sv
// Multi-cycle ASR/ROR/ROL unit: moves the operand one bit position per clock, then strobes done.
// Optional carry-out port cout is compiled in when SHIFT_CARRY_EN is defined.
module n_bit_iter_shifter #(
  parameter int max_s_bits = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2**max_s_bits-1:0]   a,
  input  logic [2**max_s_bits-1:0]   b,
  input  logic [1:0]                 ctrl,
  output logic [2**max_s_bits-1:0]   f,
  output logic                       busy,
  output logic                       done
`ifdef SHIFT_CARRY_EN
  ,
  output logic                       cout
`endif
);

  localparam int DATA_W = 2**max_s_bits;
  localparam logic [max_s_bits-1:0] CNT_ONE = 1;
  localparam logic [1:0] OP_ASR = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [max_s_bits-1:0]   count;
  logic [1:0]              op;
  logic                    accept;
  logic [max_s_bits-1:0]   amt;
  logic                    unused_b_hi;

  assign amt         = b[max_s_bits-1:0];
  assign unused_b_hi = &{1'b0, b[DATA_W-1:max_s_bits]};

  // One-bit step; the reserved code never reaches SHIFT, so it just holds.
  function automatic logic [DATA_W-1:0] step_f(input logic [DATA_W-1:0] v,
                                               input logic [1:0] o);
    logic [DATA_W-1:0] r;
    case (o)
      OP_ASR:  r = {v[DATA_W-1], v[DATA_W-1:1]};
      OP_ROR:  r = {v[0], v[DATA_W-1:1]};
      OP_ROL:  r = {v[DATA_W-2:0], v[DATA_W-1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept = 1'b1;
          if (amt == '0 || ctrl == OP_PASS) state_nxt = DONE;
          else                              state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (count == CNT_ONE) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f     <= '0;
      count <= '0;
      op    <= OP_ASR;
    end else if (accept) begin
      f     <= a;
      op    <= ctrl;
      count <= amt;
    end else if (state == SHIFT) begin
      f     <= step_f(f, op);
      count <= count - CNT_ONE;
    end
  end

`ifdef SHIFT_CARRY_EN
  // Carry tracks the bit most recently pushed out of f.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cout <= 1'b0;
    else if (accept)          cout <= 1'b0;
    else if (state == SHIFT)  cout <= (op == OP_ROL) ? f[DATA_W-1] : f[0];
  end
`endif

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_n_bit_iter_shifter.sv
// Bench for n_bit_iter_shifter (max_s_bits=3): vector table, corner sequences, random ops vs model.
module tb_n_bit_iter_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic [1:0] ctrl;
  logic [7:0] f;
  logic       busy, done;
`ifdef SHIFT_CARRY_EN
  logic       cout;
`endif

  int n_checks = 0;
  int n_err    = 0;

  n_bit_iter_shifter #(.max_s_bits(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ctrl(ctrl),
    .f(f), .busy(busy), .done(done)
`ifdef SHIFT_CARRY_EN
    , .cout(cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] c;
    logic [7:0] f;
    logic       co;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the whole operation in one arithmetic step, no per-bit iteration.
  task automatic model(input logic [7:0] x, input logic [7:0] bb, input logic [1:0] c,
                       output logic [7:0] r, output logic co);
    int n;
    logic [15:0] xx;
    logic signed [7:0] sx;
    n  = int'(bb % 8);
    xx = {x, x};
    sx = x;
    r  = x;
    co = 1'b0;
    if (c != 2'b11 && n != 0) begin
      case (c)
        2'b00: begin r = sx >>> n;      co = x[n-1]; end
        2'b01: begin r = xx[n +: 8];    co = x[n-1]; end
        default: begin r = xx[8-n +: 8]; co = x[8-n]; end
      endcase
    end
  endtask

  task automatic check_done(input string tag, input logic [7:0] ef, input logic ec);
    check({tag, " done"}, {30'd0, busy, done}, 32'h1);
    check({tag, " f"}, {24'd0, f}, {24'd0, ef});
`ifdef SHIFT_CARRY_EN
    check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
`endif
  endtask

  // poke=1 raises start with different operands while the op is still shifting.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] tc,
                        input logic [7:0] ef, input logic ec, input bit poke, input string tag);
    int n;
    n = (tc == 2'b11) ? 0 : int'(tb_[2:0]);
    @(negedge clk);
    a = ta; b = tb_; ctrl = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, {30'd0, busy, done}, 32'h2);
      if (poke && i == 1) begin start = 1'b1; a = 8'h01; b = 8'h01; ctrl = 2'b00; end
      else if (poke && i == 2) start = 1'b0;
      @(negedge clk);
    end
    check_done(tag, ef, ec);
    @(negedge clk);
    check({tag, " idle"}, {30'd0, busy, done}, 32'h0);
    check({tag, " hold"}, {24'd0, f}, {24'd0, ef});
  endtask

  initial begin
    logic [7:0] ra, rb, ef, ef2;
    logic [1:0] rc;
    logic       ec, ec2;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; ctrl = '0;
    repeat (2) @(negedge clk);
    check("reset f", {24'd0, f}, 32'h0);
    check("reset busy/done", {30'd0, busy, done}, 32'h0);
    rst = 1'b0;

    tbl[0] = '{8'h96, 8'h03, 2'b00, 8'hF2, 1'b1};
    tbl[1] = '{8'h96, 8'h03, 2'b01, 8'hD2, 1'b1};
    tbl[2] = '{8'h96, 8'h03, 2'b10, 8'hB4, 1'b0};
    tbl[3] = '{8'h5A, 8'hF8, 2'b00, 8'h5A, 1'b0};
    tbl[4] = '{8'h5A, 8'h05, 2'b11, 8'h5A, 1'b0};
    tbl[5] = '{8'h80, 8'h07, 2'b00, 8'hFF, 1'b0};
    tbl[6] = '{8'h7F, 8'h07, 2'b00, 8'h00, 1'b1};
    tbl[7] = '{8'h81, 8'h01, 2'b10, 8'h03, 1'b1};
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].f, tbl[i].co, 1'b0, $sformatf("vec%0d", i));

    run_op(8'h96, 8'h07, 2'b10, 8'h4B, 1'b1, 1'b1, "ignore_start");

    // Asynchronous reset between edges while shifting.
    @(negedge clk);
    a = 8'h96; b = 8'h05; ctrl = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst f", {24'd0, f}, 32'h0);
    check("async rst busy/done", {30'd0, busy, done}, 32'h0);
`ifdef SHIFT_CARRY_EN
    check("async rst cout", {31'd0, cout}, 32'h0);
`endif
    #1 rst = 1'b0;
    run_op(8'h96, 8'h03, 2'b00, 8'hF2, 1'b1, 1'b0, "after_rst");

    // start held high across done: the second op is accepted in DONE.
    model(8'h96, 8'h02, 2'b01, ef, ec);
    model(8'h40, 8'h01, 2'b00, ef2, ec2);
    @(negedge clk);
    a = 8'h96; b = 8'h02; ctrl = 2'b01; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("b2b busy1", {30'd0, busy, done}, 32'h2);
      @(negedge clk);
    end
    check_done("b2b op1", ef, ec);
    a = 8'h40; b = 8'h01; ctrl = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy2", {30'd0, busy, done}, 32'h2);
    @(negedge clk);
    check_done("b2b op2", ef2, ec2);

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 2'($urandom);
      model(ra, rb, rc, ef, ec);
      run_op(ra, rb, rc, ef, ec, 1'b0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
